// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
//   rx_state_t                : receive controller FSM states
//   UART_CLKS_PER_BIT_DEFAULT : 50 MHz / 115200 baud
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, resetting to 1.
//   clk : system clock
//   rst : synchronous, active-low reset
//   d   : asynchronous input
//   q   : synchronised output (second flop)
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         meta_q <= 1'b1;
         q      <= 1'b1;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronises the serial line, qualifies start bits, times each
// bit to its midpoint and strobes the downstream shift register once per data bit.
//   clk       : system clock
//   rst       : synchronous, active-low reset
//   uart_rx   : raw asynchronous serial line (idles high)
//   rx_bit    : synchronised line value for the shift register
//   load      : one-cycle strobe to capture rx_bit into bit bit_index
//   bit_index : current data bit, LSB first (0 outside DATA)
//   rx_done   : one-cycle pulse, frame with valid stop bit received
//   frame_err : one-cycle pulse, stop bit sampled low
//   busy      : controller is not idle
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx,
   output logic       rx_bit,
   output logic       load,
   output logic [2:0] bit_index,
   output logic       rx_done,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   rx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (uart_rx),
      .q   (rx_bit)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   // Strobes are decoded from registered state and the synchronised line only, so there
   // is no combinational path from uart_rx to any output.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CW'(1);
      idx_d     = idx_q;
      load      = 1'b0;
      rx_done   = 1'b0;
      frame_err = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_bit) state_d = START;
         end
         START: begin
            // Half-bit re-check rejects glitches and aligns later samples to mid-bit.
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               if (!rx_bit) begin
                  state_d = DATA;
                  idx_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt_q == FULL_M1) begin
               load  = 1'b1;
               cnt_d = '0;
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (rx_bit) begin
                  rx_done = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err = 1'b1;
                  state_d   = BREAK;
               end
            end
         end
         BREAK: begin
            // Held-low line must return high before a new start can be detected.
            cnt_d = '0;
            if (rx_bit) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign bit_index = (state_q == DATA) ? idx_q : 3'd0;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART path. It synchronises the raw serial line, detects and qualifies start bits, and times each bit to its midpoint. For each data bit it issues a one-cycle `load` strobe and a `bit_index` that drive the 8-bit receive shift register directly downstream. It flags frame completion or a framing error once the stop bit has been checked.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200): clock cycles per serial bit. Must be ≥ 4.
- `clk`  in  1  system clock (single clock domain).
- `rst`  in  1  synchronous, active-low reset.
- `uart_rx`  in  1  raw asynchronous serial line; idles high.
- `rx_bit`  out  1  synchronised line value; connects to the shift register's `uart_rx`.
- `load`  out  1  one-cycle strobe: sample `rx_bit` into bit `bit_index`.
- `bit_index`  out  3  current data bit, LSB first (0..7).
- `rx_done`  out  1  one-cycle pulse: 8 data bits and a valid stop bit received.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- **Synchroniser:** 2-FF chain on `uart_rx`, both flops reset to 1. `rx_bit` is the second flop.
- **Bit-time counter:** `cnt`, width $clog2(CLKS_PER_BIT), counts up and clears on every state change and every bit boundary. `idx` is a 3-bit data-bit counter.
- **IDLE:** when `rx_bit` == 0, go to START with `cnt` = 0.
- **START:** when `cnt` == CLKS_PER_BIT/2 − 1, re-check `rx_bit`.
  - If 0: go to DATA, `cnt` = 0, `idx` = 0.
  - If 1 (glitch): return to IDLE. No outputs are asserted.
- **DATA:** when `cnt` == CLKS_PER_BIT − 1, assert `load` for that cycle with `bit_index` = `idx`, then clear `cnt`.
  - `idx` < 7: increment `idx`.
  - `idx` == 7: go to STOP.
- **STOP:** when `cnt` == CLKS_PER_BIT − 1, sample `rx_bit`.
  - 1: pulse `rx_done`, go to IDLE.
  - 0: pulse `frame_err`, go to BREAK.
- **BREAK:** stay until `rx_bit` == 1, then go to IDLE. Start detection is suppressed while in BREAK.
- **Output qualification:**
  - `load` is only ever high in DATA.
  - `bit_index` holds `idx` at all times and is 0 outside DATA.
  - `rx_done` and `frame_err` are mutually exclusive and never high together with `load`.
- **Reset:** a reset asserted in any state returns to IDLE on the next edge; a partially received frame is discarded without `rx_done` or `frame_err`. Reset values:
  - `load` = 0, `bit_index` = 0, `rx_done` = 0, `frame_err` = 0, `busy` = 0, `rx_bit` = 1.
  - `cnt` = 0, `idx` = 0.

## Timing
- All outputs are registered or decoded from registered state. No combinational path from `uart_rx` to any output.
- Line-to-`rx_bit` latency: 2 cycles.
- Start-edge detection: IDLE sees `rx_bit` low 2 cycles after the line falls.
- Sample points relative to the start edge at `rx_bit`:
  - Data bit n is sampled at CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT cycles (≈ mid-bit).
  - The stop bit is sampled at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- `load` coincides with the edge at which the downstream register captures `rx_bit`. `rx_bit` is stable for ±CLKS_PER_BIT/2 around that edge.
- `rx_done` pulses 1 cycle after the final `load` + CLKS_PER_BIT − 1 cycles, i.e. in the stop-bit sampling cycle. The downstream 8-bit value is already final in that cycle.
- Back-to-back frames: a start bit arriving immediately after the stop bit is accepted. IDLE is occupied for at least 1 cycle.

## Structure
- Package `uart_pkg` holds:
  - `typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t`.
  - Constant `UART_CLKS_PER_BIT_DEFAULT` = 434.
- One sub-module, `sync_2ff`, with ports `clk`, `rst`, `d`, `q` and a reset value of 1. It is reusable for other asynchronous inputs.
- The FSM, `cnt` and `idx` live in `uart_rx_ctrl`. No other hierarchy.

## Test plan
All scenarios use CLKS_PER_BIT = 16.
- Frame 0xA5, valid stop bit → 8 `load` pulses 16 cycles apart with `bit_index` 0..7. `rx_bit` at each `load` = 1,0,1,0,0,1,0,1. One `rx_done`, no `frame_err`, and the downstream register reads 0xA5.
- Line low for 5 cycles, then high → returns to IDLE after the half-bit check. No `load`, `rx_done` or `frame_err`; `busy` drops.
- Frame 0x3C with stop bit held low → 8 `load` pulses and `frame_err` = 1 for one cycle, no `rx_done`. State stays BREAK until the line goes high, and a falling edge during BREAK is ignored.
- Frames 0xFF then 0x00 back-to-back, with no idle gap → both produce `rx_done`, and the second frame's 8 `load` pulses follow correctly.
- Assert `rst` = 0 during DATA after `bit_index` 3 → next cycle all outputs are at their reset values. The following full frame 0x81 is received correctly.
